// File: rtl/muldiv_hilo_unit_if.sv
// Execute-stage interface between the pipeline controller and the HI/LO multiply/divide unit.
interface muldiv_hilo_unit_if;
  localparam int unsigned DW = 32;
  localparam int unsigned OPW = 2;

  logic           start;
  logic [OPW-1:0] op;
  logic [DW-1:0]  a;
  logic [DW-1:0]  b;
  logic           mthi_en;
  logic           mtlo_en;
  logic [DW-1:0]  wdata;
  logic           busy;
  logic           done;
  logic [DW-1:0]  hi;
  logic [DW-1:0]  lo;

  // Controller side: issues operations and MTHI/MTLO, consumes HI/LO.
  modport master (
    output start, op, a, b, mthi_en, mtlo_en, wdata,
    input  busy, done, hi, lo
  );

  // Unit side.
  modport slave (
    input  start, op, a, b, mthi_en, mtlo_en, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_hilo_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// op: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV. Iterative path takes 33 cycles.
// Optional build macro MULDIV_FAST_MULT_EN: single-cycle multiply (IDLE->FIX).
module muldiv_hilo_unit #(
  parameter logic [31:0] HILO_RESET = 32'h0000_0000,
  parameter logic [31:0] DIV0_QUOT  = 32'hFFFF_FFFF
) (
  input logic             clk,
  input logic             reset,
  muldiv_hilo_unit_if.slave bus
);
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 2 * DW;
  localparam int unsigned CW  = 5;
  localparam logic [CW-1:0] LAST_ITER = CW'(DW - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic          a_neg_q, a_neg_d;
  logic          b_neg_q, b_neg_d;
  logic [DW-1:0] a_abs_q, a_abs_d;
  logic [DW-1:0] b_abs_q, b_abs_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Operand magnitudes/signs as seen in IDLE; unsigned ops pass raw values.
  logic          in_signed_c;
  logic          in_a_neg_c, in_b_neg_c;
  logic [DW-1:0] in_a_abs_c, in_b_abs_c;

  // One iteration of each algorithm, and the sign-fixed results.
  logic [DW:0]   mul_sum_c;
  logic [AW-1:0] mul_next_c;
  logic [DW:0]   div_trial_c;
  logic          div_ge_c;
  logic [DW-1:0] div_rem_c;
  logic [AW-1:0] div_next_c;
  logic [AW-1:0] prod_fix_c;
  logic [DW-1:0] quot_fix_c, rem_fix_c, a_raw_c;

  // Operand conditioning at the issue point.
  always_comb begin
    in_signed_c = bus.op[0];
    in_a_neg_c  = in_signed_c & bus.a[DW-1];
    in_b_neg_c  = in_signed_c & bus.b[DW-1];
    in_a_abs_c  = in_a_neg_c ? DW'(~bus.a + DW'(1)) : bus.a;
    in_b_abs_c  = in_b_neg_c ? DW'(~bus.b + DW'(1)) : bus.b;
  end

  // Datapath step: shift-add multiply and restoring divide sharing one accumulator.
  always_comb begin
    mul_sum_c   = {1'b0, acc_q[AW-1:DW]} + (acc_q[0] ? {1'b0, a_abs_q} : (DW+1)'(0));
    mul_next_c  = {mul_sum_c, acc_q[DW-1:1]};
    div_trial_c = acc_q[AW-1:DW-1];
    div_ge_c    = (div_trial_c >= {1'b0, b_abs_q});
    div_rem_c   = div_ge_c ? DW'(div_trial_c - {1'b0, b_abs_q}) : div_trial_c[DW-1:0];
    div_next_c  = {div_rem_c, acc_q[DW-2:0], div_ge_c};
  end

  // Sign correction: product sign from operand signs, remainder follows the dividend.
  always_comb begin
    prod_fix_c = (a_neg_q ^ b_neg_q) ? AW'(~acc_q + AW'(1)) : acc_q;
    quot_fix_c = (a_neg_q ^ b_neg_q) ? DW'(~acc_q[DW-1:0] + DW'(1)) : acc_q[DW-1:0];
    rem_fix_c  = a_neg_q ? DW'(~acc_q[AW-1:DW] + DW'(1)) : acc_q[AW-1:DW];
    a_raw_c    = a_neg_q ? DW'(~a_abs_q + DW'(1)) : a_abs_q;
  end

  // Next-state and register-input logic.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_neg_d = a_neg_q;
    b_neg_d = b_neg_q;
    a_abs_d = a_abs_q;
    b_abs_d = b_abs_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.mthi_en) hi_d = bus.wdata;
        if (bus.mtlo_en) lo_d = bus.wdata;
        if (bus.start) begin
          op_d    = bus.op;
          a_neg_d = in_a_neg_c;
          b_neg_d = in_b_neg_c;
          a_abs_d = in_a_abs_c;
          b_abs_d = in_b_abs_c;
          cnt_d   = '0;
          // Multiply shifts the multiplier out of the low half; divide shifts the dividend.
          acc_d   = bus.op[1] ? {{DW{1'b0}}, in_a_abs_c} : {{DW{1'b0}}, in_b_abs_c};
          state_d = S_RUN;
`ifdef MULDIV_FAST_MULT_EN
          if (!bus.op[1]) begin
            acc_d   = AW'(in_a_abs_c) * AW'(in_b_abs_c);
            state_d = S_FIX;
          end
`endif
        end
      end

      S_RUN: begin
        acc_d = op_q[1] ? div_next_c : mul_next_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) state_d = S_FIX;
      end

      S_FIX: begin
        if (!op_q[1]) begin
          {hi_d, lo_d} = op_q[0] ? prod_fix_c : acc_q;
        end else if (b_abs_q == '0) begin
          lo_d = DIV0_QUOT;
          hi_d = a_raw_c;
        end else begin
          lo_d = quot_fix_c;
          hi_d = rem_fix_c;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      a_abs_q <= '0;
      b_abs_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= HILO_RESET;
      lo_q    <= HILO_RESET;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
      a_abs_q <= a_abs_d;
      b_abs_q <= b_abs_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed self-checking bench for muldiv_hilo_unit.
module tb_muldiv_hilo_unit;
  localparam int LAT_DIV = 33;
`ifdef MULDIV_FAST_MULT_EN
  localparam int LAT_MUL = 1;
`else
  localparam int LAT_MUL = 33;
`endif

  logic clk;
  logic reset;
  int   total;
  int   bad;

  muldiv_hilo_unit_if bus ();

  muldiv_hilo_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Presents one start; returns at the falling edge after the accepting edge.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic mtlo, input logic [31:0] wd);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.a       = a;
    bus.b       = b;
    bus.mtlo_en = mtlo;
    bus.wdata   = wd;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.mtlo_en = 1'b0;
    bus.op      = ~op;
    bus.a       = $urandom;
    bus.b       = $urandom;
  endtask

  // Waits for done; checks latency, busy, result and single-cycle pulse.
  task automatic wait_done(input int exp_lat, input bit disturb, input string tag,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int          cyc;
    bit          seen;
    bit          busy_ok;
    logic [31:0] hi0;
    logic [31:0] lo0;
    cyc = 0; seen = 1'b0; busy_ok = 1'b1;
    hi0 = bus.hi; lo0 = bus.lo;
    while (!seen && cyc < 40) begin
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (!bus.busy) busy_ok = 1'b0;
        if (disturb && cyc == 5) begin
          bus.start = 1'b1; bus.op = 2'b00;
          bus.mthi_en = 1'b1; bus.mtlo_en = 1'b1; bus.wdata = 32'hDEAD_BEEF;
        end
        if (disturb && cyc == 6) begin
          bus.start = 1'b0; bus.mthi_en = 1'b0; bus.mtlo_en = 1'b0;
        end
        if (disturb && cyc == 7) begin
          chk({tag, "_busy_hi_hold"}, bus.hi, hi0);
          chk({tag, "_busy_lo_hold"}, bus.lo, lo0);
        end
        @(negedge clk);
        cyc++;
      end
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_busy_during"}, 32'(busy_ok), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    chk({tag, "_hi"}, bus.hi, exp_hi);
    chk({tag, "_lo"}, bus.lo, exp_lo);
    @(negedge clk);
    chk({tag, "_done_width"}, 32'(bus.done), 32'd0);
    chk({tag, "_no_requeue"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bit seen_done;
    total = 0; bad = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.mthi_en = 1'b0; bus.mtlo_en = 1'b0; bus.wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    reset = 1'b0;

    // Multiplies
    start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0);
    wait_done(LAT_MUL, 1'b0, "multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
    start_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 32'h0);
    wait_done(LAT_MUL, 1'b0, "mult_neg3x5", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    start_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0);
    wait_done(LAT_MUL, 1'b0, "mult_min_sq", 32'h4000_0000, 32'h0000_0000);

    // Divides
    start_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32'h0);
    wait_done(LAT_DIV, 1'b0, "div_neg7by2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    start_op(2'b10, 32'h0000_0007, 32'h0000_0002, 1'b0, 32'h0);
    wait_done(LAT_DIV, 1'b0, "divu_7by2", 32'h0000_0001, 32'h0000_0003);
    start_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0);
    wait_done(LAT_DIV, 1'b0, "div_ovf", 32'h0000_0000, 32'h8000_0000);
    start_op(2'b10, 32'h0000_1234, 32'h0000_0000, 1'b0, 32'h0);
    wait_done(LAT_DIV, 1'b0, "divu_by0", 32'h0000_1234, 32'hFFFF_FFFF);
    start_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0000, 1'b0, 32'h0);
    wait_done(LAT_DIV, 1'b0, "div_by0", 32'hFFFF_FFF9, 32'hFFFF_FFFF);

    // MTHI in IDLE
    @(negedge clk);
    bus.mthi_en = 1'b1; bus.wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    bus.mthi_en = 1'b0;
    chk("mthi_idle", bus.hi, 32'hA5A5_A5A5);
    chk("mthi_lo_kept", bus.lo, 32'hFFFF_FFFF);

    // MTLO and start in the same cycle
    start_op(2'b10, 32'h0000_0007, 32'h0000_0002, 1'b1, 32'h1357_2468);
    chk("mtlo_with_start", bus.lo, 32'h1357_2468);
    wait_done(LAT_DIV, 1'b0, "divu_after_mtlo", 32'h0000_0001, 32'h0000_0003);

    // MTHI/MTLO/start while busy are ignored
    start_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32'h0);
    wait_done(LAT_DIV, 1'b1, "div_disturbed", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // Reset mid-operation
    start_op(2'b10, 32'd1000, 32'd3, 1'b0, 32'h0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_hi", bus.hi, 32'h0);
    chk("midrst_lo", bus.lo, 32'h0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen_done = 1'b1;
    end
    chk("midrst_no_done", 32'(seen_done), 32'd0);
    start_op(2'b10, 32'd100, 32'd7, 1'b0, 32'h0);
    wait_done(LAT_DIV, 1'b0, "divu_100by7", 32'd2, 32'd14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
- Multi-cycle multiply/divide unit that owns the architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits beside the ALU in the execute stage. The ALU supplies operands, and the ALU's MFHI/MFLO result path consumes hi/lo from this block.
- Raises busy so the pipeline controller stalls any HI/LO consumer until the result is written.

Parameters:
- HILO_RESET, 32'h00000000, value loaded into HI and LO on reset.
- DIV0_QUOT, 32'hFFFFFFFF, LO value written on divide-by-zero.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request to begin an operation; sampled only in IDLE
- op  in  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- a  in  32  rs operand (multiplicand / dividend)
- b  in  32  rt operand (multiplier / divisor)
- mthi_en  in  1  write wdata to HI
- mtlo_en  in  1  write wdata to LO
- wdata  in  32  MTHI/MTLO data
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; hi/lo hold the new result
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset has priority over everything and may be asserted mid-operation:
  - state becomes IDLE; busy=0; done=0.
  - hi=lo=HILO_RESET.
  - any in-flight result is discarded.
- States: IDLE, RUN, FIX. busy = (state != IDLE). busy and done are registered outputs.
- IDLE:
  - start=1 at edge 0: latch op, |a| and |b| (absolute values for signed ops, raw for unsigned) and the operand signs; clear the iteration counter; go to RUN.
  - start=0: stay in IDLE.
- RUN: one iteration per cycle, 32 cycles (edges 1..32), then go to FIX.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring divide, 1 quotient bit per cycle, 33-bit partial remainder.
- FIX (edge 33):
  - Apply the sign correction and write hi/lo.
  - done=1 during the cycle after edge 33; state returns to IDLE at the same edge.
  - Total latency: start sampled at edge 0, result visible after edge 33 (33 cycles).
- Arithmetic:
  - MULT/MULTU: {HI,LO} = 64-bit product. MULT negates the product when the operand signs differ.
  - DIV/DIVU: LO = quotient, HI = remainder. Signed divide truncates toward zero; the remainder takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (no trap).
  - Divide by zero (signed or unsigned): LO=DIV0_QUOT, HI=a. FIX is still reached at edge 33, so latency is unchanged.
- Handshake:
  - start while busy=1 is ignored and does not queue.
  - The controller must hold a new start until busy=0.
  - The done cycle itself is IDLE, so a back-to-back start is accepted during done.
- MTHI/MTLO:
  - In IDLE, write HI/LO at the clock edge; the new value is visible the next cycle.
  - While busy, they are ignored.
  - If start and mthi_en/mtlo_en occur in the same IDLE cycle, both are accepted; the operation result later overwrites HI and LO.
  - mthi_en and mtlo_en together write both registers.
- hi/lo change only on reset, an accepted MTHI/MTLO, or FIX.
- Operands a and b need not be held after start is accepted.

Optional Feature:
- Macro: MULDIV_FAST_MULT_EN.
- Defined:
  - MULT/MULTU use a single-cycle 64-bit multiplier and skip RUN: IDLE->FIX.
  - hi/lo are written at edge 1; done is high during the cycle after edge 1; busy is high for one cycle.
  - Divide is unchanged at 33 cycles.
- Undefined: all operations use the iterative 33-cycle path described above.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; done pulses exactly one cycle, after edge 33 (after edge 1 with MULDIV_FAST_MULT_EN); busy=1 throughout the operation.
- MULT a=0xFFFFFFFD (-3), b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Then MULT 0x80000000 * 0x80000000 -> HI=0x40000000, LO=0.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7, b=2 -> LO=3, HI=1. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU a=0x1234, b=0 -> LO=0xFFFFFFFF, HI=0x1234 after 33 cycles. DIV with b=0 -> same rule.
- MTHI wdata=0xA5A5A5A5 in IDLE -> hi=0xA5A5A5A5 next cycle. mtlo_en and start in the same cycle -> lo takes wdata, then the result at done. MTHI and start pulses while busy -> no effect, and the result matches the original operation.
- Reset asserted at RUN iteration 10 -> next cycle busy=0, done=0, hi=lo=0, and no done pulse follows. A fresh DIVU 100/7 afterwards -> LO=14, HI=2.
